// File: rtl/nes_spr_dma_if.sv
`default_nettype none
//============================================================================
// Module   : nes_spr_dma_if
// Brief    : Bus bundle between the sprite DMA engine and the console bus
//            arbiter: snooped arbitrated-bus signals plus the spr master port.
// Revision : 1.0 - initial release
//============================================================================
interface nes_spr_dma_if;
   logic [15:0] i_bus_addr;
   logic [7:0]  i_bus_wdata;
   logic        i_bus_wn;
   logic        o_spr_req;
   logic        i_spr_gnt;
   logic [15:0] o_spr_addr;
   logic        o_spr_wn;
   logic [7:0]  o_spr_wdata;
   logic [7:0]  i_spr_rdata;
   logic        o_busy;
   logic        o_done;

   // DMA engine side
   modport master (
      input  i_bus_addr, i_bus_wdata, i_bus_wn, i_spr_gnt, i_spr_rdata,
      output o_spr_req, o_spr_addr, o_spr_wn, o_spr_wdata, o_busy, o_done
   );

   // Arbiter / memory side
   modport slave (
      output i_bus_addr, i_bus_wdata, i_bus_wn, i_spr_gnt, i_spr_rdata,
      input  o_spr_req, o_spr_addr, o_spr_wn, o_spr_wdata, o_busy, o_done
   );
endinterface
`default_nettype wire

// File: rtl/nes_spr_dma.sv
`default_nettype none
//============================================================================
// Module   : nes_spr_dma
// Brief    : Sprite (OAM) DMA engine. Snoops CPU writes to $4014, then copies
//            page $XX00-$XXFF to $2004 as alternating granted read/write
//            transactions, stalling whenever the arbiter withholds the grant.
// Config   : NES_SPR_DMA_ALIGN_EN - insert one extra dummy cycle so the first
//            read lands on an even CPU cycle (2A03 odd-cycle behaviour).
// Revision : 1.0 - initial release
//============================================================================
module nes_spr_dma #(
   parameter logic [15:0] P_TRIG_ADDR = 16'h4014,
   parameter logic [15:0] P_OAM_ADDR  = 16'h2004
) (
   input wire           i_clk,
   input wire           i_rstn,
   nes_spr_dma_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
`ifdef NES_SPR_DMA_ALIGN_EN
      S_ALIGN = 3'd2,
`endif
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t      r_state;
   logic [7:0]  r_page;
   logic [7:0]  r_idx;
   logic [7:0]  r_data;
   logic        r_req;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_addr;
   logic        r_wn;
`ifdef NES_SPR_DMA_ALIGN_EN
   logic        r_cyc_odd;
`endif

   logic        w_trigger;

   // The engine never writes $4014 itself, and the request is low only in
   // IDLE, so its own traffic cannot retrigger it.
   assign w_trigger = (bus.i_bus_addr == P_TRIG_ADDR) && !bus.i_bus_wn && !r_req;

   // Every output comes straight from a register.
   assign bus.o_spr_req   = r_req;
   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_spr_addr  = r_addr;
   assign bus.o_spr_wn    = r_wn;
   assign bus.o_spr_wdata = r_data;

   // Transfer sequencer; outputs are computed for the state being entered.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_IDLE;
         r_page  <= 8'h00;
         r_idx   <= 8'h00;
         r_data  <= 8'h00;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_addr  <= 16'h0000;
         r_wn    <= 1'b1;
`ifdef NES_SPR_DMA_ALIGN_EN
         r_cyc_odd <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef NES_SPR_DMA_ALIGN_EN
         r_cyc_odd <= ~r_cyc_odd;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  r_page  <= bus.i_bus_wdata;
                  r_idx   <= 8'h00;
                  r_req   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_addr  <= {bus.i_bus_wdata, 8'h00};
                  r_wn    <= 1'b1;
                  r_state <= S_HALT;
               end
            end

            // Dummy cycle: advances whether or not granted.
            S_HALT: begin
`ifdef NES_SPR_DMA_ALIGN_EN
               if (!r_cyc_odd) begin
                  r_state <= S_ALIGN;
               end else begin
                  r_addr  <= {r_page, r_idx};
                  r_state <= S_READ;
               end
`else
               r_addr  <= {r_page, r_idx};
               r_state <= S_READ;
`endif
            end

`ifdef NES_SPR_DMA_ALIGN_EN
            S_ALIGN: begin
               r_addr  <= {r_page, r_idx};
               r_state <= S_READ;
            end
`endif

            S_READ: begin
               if (bus.i_spr_gnt) begin
                  r_data  <= bus.i_spr_rdata;
                  r_addr  <= P_OAM_ADDR;
                  r_wn    <= 1'b0;
                  r_state <= S_WRITE;
               end
            end

            S_WRITE: begin
               if (bus.i_spr_gnt) begin
                  if (r_idx == 8'hFF) begin
                     r_req   <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_addr  <= 16'h0000;
                     r_wn    <= 1'b1;
                     r_data  <= 8'h00;
                     r_state <= S_IDLE;
                  end else begin
                     // Index wraps within the page; no carry into r_page.
                     r_idx   <= r_idx + 8'd1;
                     r_addr  <= {r_page, r_idx + 8'd1};
                     r_wn    <= 1'b1;
                     r_state <= S_READ;
                  end
               end
            end

            default: begin
               r_req   <= 1'b0;
               r_busy  <= 1'b0;
               r_addr  <= 16'h0000;
               r_wn    <= 1'b1;
               r_data  <= 8'h00;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nes_spr_dma.sv
`default_nettype none
//============================================================================
// Module   : tb_nes_spr_dma
// Brief    : Self-checking bench for nes_spr_dma: scenario table, hand-made
//            corner sequences and randomized traffic against a transaction
//            level reference model.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
module tb_nes_spr_dma;

`ifdef NES_SPR_DMA_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nes_spr_dma_if bus();

   nes_spr_dma dut (
      .i_clk  (clk),
      .i_rstn (rst_n),
      .bus    (bus)
   );

   // Memory model: byte = low address byte XOR a per-transfer key.
   logic [7:0] key;
   always_comb bus.i_spr_rdata = bus.o_spr_addr[7:0] ^ key;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a transfer is 512 granted transactions (even = read
   // {page,idx}, odd = write idx^key to $2004) preceded by dummy cycle(s).
   bit         m_active;
   bit         m_done;
   int         m_dummy;
   int         m_ptr;
   logic [7:0] m_page;
   int         ecnt;        // clock edges since reset release
   logic [7:0] wq[$];       // bytes observed on granted writes

   typedef struct {
      logic [7:0] page;
      logic [7:0] key;
      int         sa, la, sb, lb;   // stall at transaction index, length
      int         retrig;           // transaction index of a $4014 write
      int         exp_cycles;       // request-high cycles (no alignment)
      logic [7:0] exp_first, exp_last;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [15:0] ea;
      logic        ew;
      logic [7:0]  ed;
      bit          dc;
      dc = 1'b0; ea = 16'h0000; ew = 1'b1; ed = 8'h00;
      if (m_active) begin
         if (m_dummy > 0) begin
            ea = {m_page, 8'h00}; dc = 1'b1;
         end else if (m_ptr % 2 == 0) begin
            ea = {m_page, 8'(m_ptr / 2)}; dc = 1'b1;
         end else begin
            ea = 16'h2004; ew = 1'b0; ed = 8'(m_ptr / 2) ^ key;
         end
      end
      check("cycle",
            {bus.o_spr_req, bus.o_busy, bus.o_done, bus.o_spr_addr, bus.o_spr_wn,
             dc ? 8'h00 : bus.o_spr_wdata},
            {m_active, m_active, m_done, ea, ew, ed});
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic step(input bit trig, input logic [7:0] tpage, input bit gnt);
      logic [15:0] na;
      check_outputs();
      if (bus.o_spr_req && !bus.o_spr_wn && gnt) wq.push_back(bus.o_spr_wdata);
      bus.i_spr_gnt = gnt;
      if (trig) begin
         bus.i_bus_addr  = 16'h4014;
         bus.i_bus_wn    = 1'b0;
         bus.i_bus_wdata = tpage;
      end else begin
         na = 16'($urandom_range(0, 16'hFFFF));
         bus.i_bus_addr  = na;
         bus.i_bus_wn    = (na == 16'h4014) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.i_bus_wdata = 8'($urandom_range(0, 255));
      end
      m_done = 1'b0;
      if (!m_active) begin
         if (trig) begin
            m_active = 1'b1;
            m_page   = tpage;
            m_ptr    = 0;
            m_dummy  = (ALIGN && ((ecnt + 1) % 2 == 0)) ? 2 : 1;
         end
      end else if (m_dummy > 0) begin
         m_dummy--;
      end else if (gnt) begin
         m_ptr++;
         if (m_ptr == 512) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
      @(posedge clk);
      ecnt++;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check("rst_req_async", bus.o_spr_req, 1'b0);
      check("rst_busy_async", bus.o_busy, 1'b0);
      m_active = 1'b0; m_done = 1'b0; m_dummy = 0; m_ptr = 0; ecnt = 0;
      bus.i_spr_gnt = 1'b0; bus.i_bus_wn = 1'b1;
      bus.i_bus_addr = 16'h0000; bus.i_bus_wdata = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_addr", bus.o_spr_addr, 16'h0000);
      check("rst_wn", bus.o_spr_wn, 1'b1);
      check("rst_wdata", bus.o_spr_wdata, 8'h00);
      check("rst_done", bus.o_done, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic check_bytes(input string name, input logic [7:0] k);
      int bad;
      bad = 0;
      foreach (wq[i]) if (wq[i] !== (8'(i) ^ k)) bad++;
      check({name, "_nbytes"}, wq.size(), 256);
      check({name, "_bad_bytes"}, bad, 0);
   endtask

   task automatic run_transfer(input vec_t v, output int req_cycles, output int first_off,
                               output int dones, output bit halt_even);
      int  ca, cb;
      bit  g, t;
      key = v.key;
      wq.delete();
      req_cycles = 0; first_off = -1; dones = 0; ca = 0; cb = 0;
      halt_even = ((ecnt + 1) % 2 == 0);
      step(1'b1, v.page, 1'b1);
      for (int k = 1; k < 3000 && (m_active || m_done); k++) begin
         if (bus.o_spr_req) req_cycles++;
         if (bus.o_done) dones++;
         if (first_off < 0 && bus.o_spr_req && !bus.o_spr_wn) first_off = k;
         g = 1'b1;
         if (m_active && m_dummy == 0) begin
            if (m_ptr == v.sa && ca < v.la) begin g = 1'b0; ca++; end
            else if (m_ptr == v.sb && cb < v.lb) begin g = 1'b0; cb++; end
         end
         t = m_active && (m_ptr == v.retrig);
         step(t, 8'h77, g);
      end
      check("transfer_timeout", m_active || m_done, 1'b0);
   endtask

   initial begin
      int rc, fo, dn, ra, rb, x;
      bit he, he1;
      bit g, t;
      vec_t v;

      tbl[0] = '{8'h02, 8'hA5, -1, 0, -1, 0, -1, 513, 8'hA5, 8'h5A};
      tbl[1] = '{8'hFF, 8'h00, -1, 0, -1, 0, -1, 513, 8'h00, 8'hFF};
      tbl[2] = '{8'h02, 8'hA5, 32, 3, 33, 3, -1, 519, 8'hA5, 8'h5A};
      tbl[3] = '{8'h80, 8'h3C,  0, 1, 511, 1, -1, 515, 8'h3C, 8'hC3};
      tbl[4] = '{8'h02, 8'hA5, -1, 0, -1, 0, 128, 513, 8'hA5, 8'h5A};

      key = 8'hA5;
      bus.i_spr_gnt = 1'b0; bus.i_bus_wn = 1'b1;
      bus.i_bus_addr = 16'h0000; bus.i_bus_wdata = 8'h00;
      @(negedge clk);
      apply_reset();
      repeat (3) step(1'b0, 8'h00, 1'b1);

      // Scenario table
      for (int i = 0; i < 5; i++) begin
         run_transfer(tbl[i], rc, fo, dn, he);
         check("req_cycles", rc, tbl[i].exp_cycles + ((ALIGN && he) ? 1 : 0));
         check("done_pulses", dn, 1);
         check("first_byte", wq[0], tbl[i].exp_first);
         check("last_byte", wq[wq.size() - 1], tbl[i].exp_last);
         check_bytes("tbl", tbl[i].key);
         repeat (2) step(1'b0, 8'h00, 1'b1);
      end

      // First write offset on both HALT parities
      v = tbl[0];
      run_transfer(v, rc, fo, dn, he1);
      check("first_write_offset_a", fo, 3 + ((ALIGN && he1) ? 1 : 0));
      if (((ecnt + 1) % 2 == 0) == he1) step(1'b0, 8'h00, 1'b1);
      run_transfer(v, rc, fo, dn, he);
      check("parity_differs", he, !he1);
      check("first_write_offset_b", fo, 3 + ((ALIGN && he) ? 1 : 0));

      // Reset in the middle of the transfer, at the read of idx 8'h80
      key = 8'h11;
      step(1'b1, 8'h33, 1'b1);
      for (int k = 0; k < 2000 && !(m_active && m_dummy == 0 && m_ptr == 256); k++)
         step(1'b0, 8'h00, 1'b1);
      check("reached_idx80", m_ptr, 256);
      apply_reset();
      x = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.o_spr_req) x++;
         step(1'b0, 8'h00, 1'($urandom_range(0, 1)));
      end
      check("idle_after_reset", x, 0);
      v = tbl[0]; v.page = 8'h44; v.key = 8'h5C; v.exp_first = 8'h5C; v.exp_last = 8'hA3;
      run_transfer(v, rc, fo, dn, he);
      check("restart_req_cycles", rc, 513 + ((ALIGN && he) ? 1 : 0));
      check("restart_last", wq[wq.size() - 1], v.exp_last);
      check_bytes("restart", v.key);

      // Randomized traffic: random grant, gaps, pages, keys and $4014 writes
      for (int n = 0; n < 6; n++) begin
         ra = $urandom_range(0, 5);
         for (int k = 0; k < ra; k++) step(1'b0, 8'h00, 1'($urandom_range(0, 1)));
         key = 8'($urandom_range(0, 255));
         wq.delete();
         step(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         rb = 0;
         for (int k = 0; k < 4000 && (m_active || m_done); k++) begin
            g = ($urandom_range(0, 3) != 0);
            t = m_active && ($urandom_range(0, 19) == 0);
            step(t, 8'($urandom_range(0, 255)), g);
            rb++;
         end
         check("rand_timeout", m_active || m_done, 1'b0);
         check_bytes("rand", key);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nes_spr_dma.md
# nes_spr_dma

Sprite (OAM) DMA engine: a bus master on the NES console bus that the bus arbiter serves on its `spr` master port. It snoops CPU writes to $4014, requests the bus, and copies 256 bytes from CPU page $XX00–$XXFF to the PPU OAM data port $2004 as alternating read/write transactions. DMC requests keep priority: the engine stalls whenever it is not granted. While the engine holds its request, the CPU is paused by the arbiter.

## Interface
Parameters:
- `P_TRIG_ADDR`, 16'h4014, CPU write address that starts a transfer
- `P_OAM_ADDR`, 16'h2004, destination address for every write

Ports:
- `i_clk`  in  1  system clock; one bus transaction per cycle
- `i_rstn`  in  1  asynchronous active-low reset
- `i_bus_addr`  in  16  arbitrated bus address (snooped)
- `i_bus_wdata`  in  8  arbitrated bus write data (snooped)
- `i_bus_wn`  in  1  arbitrated bus direction; 1 read, 0 write
- `o_spr_req`  out  1  bus request
- `i_spr_gnt`  in  1  bus grant; a transaction counts only in a granted cycle
- `o_spr_addr`  out  16  master address
- `o_spr_wn`  out  1  1 read, 0 write
- `o_spr_wdata`  out  8  write data
- `i_spr_rdata`  in  8  read data; combinational, valid in the same granted cycle
- `o_busy`  out  1  high from trigger until the final write completes
- `o_done`  out  1  one-cycle pulse after the final write

## Operation
- States: IDLE, HALT, ALIGN (only with the macro), READ, WRITE.
- Registers: `page[7:0]`, `idx[7:0]`, `data[7:0]`, `cyc_odd` (toggles every cycle from reset).
- IDLE: trigger when `i_bus_addr==P_TRIG_ADDR && i_bus_wn==0 && !o_spr_req`. Latch `page<=i_bus_wdata` and `idx<=0`, then go to HALT.
- HALT: one dummy cycle. The request is asserted, `o_spr_addr={page,8'h00}`, `wn=1`, and read data is discarded. The state advances regardless of grant.
- READ: `o_spr_addr={page,idx}`, `wn=1`. If granted, `data<=i_spr_rdata` and go to WRITE. Otherwise hold.
- WRITE: `o_spr_addr=P_OAM_ADDR`, `wn=0`, `o_spr_wdata=data`. If granted:
  - if `idx==8'hFF`, go to IDLE and pulse `o_done`;
  - otherwise `idx<=idx+1` (8-bit, no carry into page) and go to READ.
  - If not granted, hold.
- `o_spr_req` and `o_busy` are high in every state except IDLE.
- In IDLE, `o_spr_addr=0`, `o_spr_wn=1`, `o_spr_wdata=0`.
- A trigger while busy is ignored. Bus writes to $4014 made by this engine never retrigger it.
- Reset asserted mid-transfer aborts immediately: state goes to IDLE, all registers clear, and no further requests are made.

## Timing
- Reset values: `o_spr_req=0`, `o_busy=0`, `o_done=0`, `o_spr_addr=0`, `o_spr_wn=1`, `o_spr_wdata=0`, `cyc_odd=0`.
- Trigger seen in cycle T: `o_spr_req=1` from T+1 (HALT). The first READ is at T+2, or T+3 with alignment inserted.
- With grant held continuously: 512 transfer cycles plus the dummy cycle(s).
- `o_done` is high in the cycle after the last granted WRITE; `o_spr_req` is 0 in that same cycle.
- A stalled cycle (`gnt=0`) holds address, direction, data and `idx` unchanged. A DMC steal during READ causes no data loss.

## Configuration
- `NES_SPR_DMA_ALIGN_EN` defined: if HALT occurs with `cyc_odd==0`, enter ALIGN for one extra dummy cycle (same outputs as HALT), so the first READ lands on `cyc_odd==0`. Total is 513 or 514 cycles, matching 2A03 odd-cycle behaviour.
- Not defined: there is no ALIGN state; HALT always goes straight to READ, giving 513 cycles unstalled.

## Test plan
- Write $4014 with data 8'h02, grant tied high. Expect 256 reads $0200–$02FF, each followed by a write to $2004 of the byte read. `o_done` pulses exactly once, and `o_spr_req` falls 513 cycles after T+1 (macro off).
- Memory model returns `addr[7:0]^8'hA5`. Expect the write data sequence 8'hA5, 8'hA4, …, 8'h5A in order.
- Drop `i_spr_gnt` for 3 cycles during READ of idx 8'h10, then during the following WRITE. Expect outputs frozen while stalled, no duplicate or missing bytes, and total length extended by 6 cycles.
- Write $4014 again at idx 8'h40 mid-transfer. Expect it ignored: `page` is unchanged and the transfer ends normally.
- Deassert `i_rstn` at idx 8'h80. Expect `o_spr_req=0` and `o_busy=0` asynchronously. After release, stay IDLE until a new $4014 write.
- Macro on: trigger with HALT on `cyc_odd==0`, then with HALT on `cyc_odd==1`. Expect the first READ at T+3 and T+2 respectively, always with `cyc_odd==0`.
